data_mem_responder: RTL and testbench

// Memory-side responder for the 16-bit RISC core's data-memory accesses; the core's mem_read/mem_write strobes are the initiator side.

---
 rtl/data_mem_responder.sv | 195 +++++++++++++++++++
 tb/tb_data_mem_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Memory-side responder for the 16-bit RISC core's data-memory
//                accesses. Accepts one read or write per transaction, waits
//                WAIT_CYCLES programmable wait states, then services it from a
//                local word array and returns a one-cycle done pulse.
//                Malformed requests are rejected with a one-cycle err pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2,
  parameter     INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [15:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // Array index width; a legal address is always below DEPTH, so only these
  // low bits are needed once the request has passed the range check.
  localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_WAIT = 2'd1;
  localparam logic [1:0] c_ST_RESP = 2'd2;

  localparam logic [3:0]      c_WAIT_LAST = 4'(WAIT_CYCLES);
  localparam logic [ADDR_W:0] c_DEPTH     = (ADDR_W + 1)'(DEPTH);

  // --------------------------------------------------------------------------
  // Storage and state
  // --------------------------------------------------------------------------
  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [3:0]         r_cnt;
  logic               r_op_wr;
  logic [c_IDX_W-1:0] r_idx;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_done;
  logic               r_err;

  logic [DATA_W-1:0]  r_mem [DEPTH];

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic       w_idle;
  logic       w_req_any;
  logic       w_req_one;
  logic       w_hi_zero;
  logic       w_lo_in_range;
  logic       w_addr_ok;
  logic       w_accept;
  logic       w_reject;
  logic [3:0] w_cnt_inc;
  logic       w_wait_last;

  // Upper address bits beyond the indexed field must be zero; when the index
  // field already spans the whole bus there is nothing to check.
  generate
    if (ADDR_W < 16) begin : g_hi_chk
      assign w_hi_zero = (addr[15:ADDR_W] == '0);
    end else begin : g_hi_none
      assign w_hi_zero = 1'b1;
    end
  endgenerate

  assign w_lo_in_range = ({1'b0, addr[ADDR_W-1:0]} < c_DEPTH);
  assign w_addr_ok     = w_hi_zero & w_lo_in_range;

  assign w_idle    = (r_state == c_ST_IDLE);
  assign w_req_any = mem_read | mem_write;
  assign w_req_one = mem_read ^ mem_write;

  // Strobes are only looked at in IDLE, so anything the core does while a
  // transaction is in flight is invisible here.
  assign w_accept = w_idle & w_req_one & w_addr_ok;
  assign w_reject = w_idle & w_req_any & ~(w_req_one & w_addr_ok);

  // The counter holds the number of wait states already spent; the last one
  // is the cycle in which the incremented value reaches WAIT_CYCLES.
  assign w_cnt_inc   = r_cnt + 4'd1;
  assign w_wait_last = (w_cnt_inc == c_WAIT_LAST);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  // State register: reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: IDLE -> (WAIT ->) RESP -> IDLE; zero wait states skip WAIT.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (WAIT_CYCLES == 0) ? c_ST_RESP : c_ST_WAIT;
        end
      end
      c_ST_WAIT: begin
        if (w_wait_last) begin
          w_state_nxt = c_ST_RESP;
        end
      end
      c_ST_RESP: begin
        w_state_nxt = c_ST_IDLE;
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
      end
    endcase
  end

  // Outputs: busy follows the state directly; done/err/rdata are registered.
  always_comb begin
    busy  = (r_state != c_ST_IDLE);
    done  = r_done;
    err   = r_err;
    rdata = r_rdata;
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  // Wait-state counter: runs only in WAIT and is cleared on leaving it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else if (r_state == c_ST_WAIT) begin
      r_cnt <= w_wait_last ? 4'd0 : w_cnt_inc;
    end else begin
      r_cnt <= 4'd0;
    end
  end

  // Request capture at accept; later input changes cannot disturb the access.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_wr <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_op_wr <= mem_write;
      r_idx   <= addr[c_IDX_W-1:0];
      r_wdata <= wdata;
    end
  end

  // Response registers: done in the cycle after RESP, err in the cycle after
  // a rejected request, rdata reloaded only by a completing read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_done <= (r_state == c_ST_RESP);
      r_err  <= w_reject;
      if ((r_state == c_ST_RESP) && !r_op_wr) begin
        r_rdata <= r_mem[r_idx];
      end
    end
  end

  // Array write port: contents survive reset, but a reset arriving in RESP
  // must still stop the pending write from landing.
  always_ff @(posedge clk) begin
    if (!rst && (r_state == c_ST_RESP) && r_op_wr) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Scoreboard bench for data_mem_responder. The driver issues
//                requests and pushes the expected response (kind, cycle, data)
//                into a queue; a monitor pops and compares whenever done or
//                err is seen. A second, zero-wait-state instance gets a few
//                directed checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  localparam int c_W  = 2;    // wait states of the main instance
  localparam int c_W0 = 0;    // wait states of the second instance

  logic        clk;
  logic        rst;
  logic        mem_read, mem_write;
  logic [15:0] addr, wdata;
  logic        busy, done, err;
  logic [15:0] rdata;

  logic        rd0, wr0;
  logic [15:0] addr0, wdata0;
  logic        busy0, done0, err0;
  logic [15:0] rdata0;

  data_mem_responder #(
    .DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(c_W), .INIT_FILE("")
  ) u_dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .rdata(rdata), .err(err)
  );

  data_mem_responder #(
    .DATA_W(16), .ADDR_W(8), .DEPTH(16), .WAIT_CYCLES(c_W0), .INIT_FILE("")
  ) u_dut0 (
    .clk(clk), .rst(rst), .mem_read(rd0), .mem_write(wr0),
    .addr(addr0), .wdata(wdata0), .busy(busy0), .done(done0),
    .rdata(rdata0), .err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: at a falling edge it equals the number of rising edges so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: plain word array plus "has been written" flags
  // --------------------------------------------------------------------------
  typedef struct {
    bit          is_err;
    int          cyc;
    bit          chk;
    logic [15:0] data;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m_mem   [256];
  bit          m_known [256];
  logic [15:0] m_last       = 16'h0000;
  bit          m_last_known = 1'b1;

  // Issue one request at the current falling edge and return at the first
  // falling edge where a new request may be presented. Non-hold requests
  // scramble all inputs while busy; those changes must be ignored.
  task automatic issue(input bit rd, input bit wr, input logic [15:0] a,
                       input logic [15:0] d, input bit hold);
    exp_t e;
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = d;
    if (!rd && !wr) begin
      @(negedge clk);
      return;
    end
    if ((rd && wr) || (a >= 16'd256)) begin
      e.is_err = 1'b1;
      e.cyc    = cyc + 1;
      e.chk    = m_last_known;
      e.data   = m_last;
      q.push_back(e);
      @(negedge clk);
      if (!hold) begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
      return;
    end
    if (wr) begin
      m_mem[a[7:0]]   = d;
      m_known[a[7:0]] = 1'b1;
    end else begin
      m_last       = m_mem[a[7:0]];
      m_last_known = m_known[a[7:0]];
    end
    e.is_err = 1'b0;
    e.cyc    = cyc + c_W + 2;
    e.chk    = m_last_known;
    e.data   = m_last;
    q.push_back(e);
    for (int i = 0; i < c_W + 2; i++) begin
      @(negedge clk);
      if (!hold && i < c_W + 1) begin
        mem_read  = 1'($urandom);
        mem_write = 1'($urandom);
        addr      = 16'($urandom);
        wdata     = 16'($urandom);
      end
    end
    if (!hold) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor: pop and compare on every done/err, flag overdue responses
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done || err) begin
        if (q.size() == 0) begin
          check("unexpected_response", {30'b0, done, err}, 32'd0);
        end else begin
          e = q.pop_front();
          check("response_kind", {30'b0, done, err}, e.is_err ? 32'd1 : 32'd2);
          check("response_cycle", cyc, e.cyc);
          check("busy_at_response", {31'b0, busy}, 32'd0);
          if (e.chk) check("rdata", {16'b0, rdata}, {16'b0, e.data});
        end
      end else if (q.size() != 0 && q[0].cyc < cyc) begin
        n_vec++;
        n_bad++;
        $display("FAIL response_timeout: got none expected response at cycle %0d (now %0d)",
                 q[0].cyc, cyc);
        void'(q.pop_front());
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int r;
    logic [15:0] a;
    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
    rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",  {31'b0, busy},  32'd0);
    check("reset_done",  {31'b0, done},  32'd0);
    check("reset_err",   {31'b0, err},   32'd0);
    check("reset_rdata", {16'b0, rdata}, 32'd0);
    check("reset_busy0", {31'b0, busy0}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait-state instance: write then read addr 0, then an out-of-range read.
    rd0 = 1'b0; wr0 = 1'b1; addr0 = 16'd0; wdata0 = 16'h1234;
    @(negedge clk);
    check("w0_busy_wr", {31'b0, busy0}, 32'd1);
    wr0 = 1'b0;
    @(negedge clk);
    check("w0_done_wr", {31'b0, done0}, 32'd1);
    rd0 = 1'b1; addr0 = 16'd0;
    @(negedge clk);
    check("w0_busy_rd", {31'b0, busy0}, 32'd1);
    check("w0_no_early_done", {31'b0, done0}, 32'd0);
    rd0 = 1'b0;
    @(negedge clk);
    check("w0_done_rd",  {31'b0, done0},  32'd1);
    check("w0_rdata",    {16'b0, rdata0}, 32'h1234);
    check("w0_busy_end", {31'b0, busy0},  32'd0);
    rd0 = 1'b1; addr0 = 16'd20;
    @(negedge clk);
    check("w0_err_range", {31'b0, err0},  32'd1);
    check("w0_err_busy",  {31'b0, busy0}, 32'd0);
    rd0 = 1'b0;
    @(negedge clk);
    check("w0_err_pulse", {31'b0, err0}, 32'd0);

    // Write then read back through the wait states.
    issue(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
    issue(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);

    // Rejects: both strobes, and an address with upper bits set.
    issue(1'b0, 1'b1, 16'h0003, 16'h3333, 1'b0);
    issue(1'b1, 1'b1, 16'h0003, 16'hFFFF, 1'b0);
    issue(1'b0, 1'b1, 16'h0100, 16'hFFFF, 1'b0);
    issue(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0);

    // Strobe held continuously: repeated identical accesses back to back.
    issue(1'b0, 1'b1, 16'h0007, 16'h5555, 1'b1);
    issue(1'b0, 1'b1, 16'h0007, 16'h5555, 1'b1);
    issue(1'b0, 1'b1, 16'h0007, 16'h5555, 1'b0);
    issue(1'b1, 1'b0, 16'h0007, 16'h0000, 1'b0);

    // Top word, with the read raised in the write's done cycle.
    issue(1'b0, 1'b1, 16'h00FF, 16'hA5A5, 1'b0);
    issue(1'b1, 1'b0, 16'h00FF, 16'h0000, 1'b0);

    // Reset in the middle of a write's wait states.
    issue(1'b0, 1'b1, 16'h0005, 16'h1111, 1'b0);
    issue(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0);
    mem_write = 1'b1; addr = 16'h0005; wdata = 16'hDEAD;
    @(negedge clk);
    mem_write = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_busy",  {31'b0, busy},  32'd0);
    check("midreset_done",  {31'b0, done},  32'd0);
    check("midreset_rdata", {16'b0, rdata}, 32'd0);
    rst = 1'b0;
    m_last = 16'h0000;
    m_last_known = 1'b1;
    @(negedge clk);
    check("postreset_done", {31'b0, done}, 32'd0);
    issue(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0);

    // Random traffic over a small address pool so reads hit written words.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 11);
      a = ($urandom_range(0, 3) == 0) ? 16'h00FF : 16'($urandom_range(0, 7));
      if (r < 4)       issue(1'b0, 1'b1, a, 16'($urandom), 1'($urandom_range(0, 7) == 0));
      else if (r < 8)  issue(1'b1, 1'b0, a, 16'($urandom), 1'($urandom_range(0, 7) == 0));
      else if (r == 8) issue(1'b1, 1'b1, a, 16'($urandom), 1'b0);
      else if (r == 9) issue(1'($urandom), 1'b1, 16'h0100 | 16'($urandom), 16'($urandom), 1'b0);
      else             issue(1'b0, 1'b0, a, 16'h0000, 1'b0);
    end
    mem_read = 1'b0;
    mem_write = 1'b0;

    repeat (c_W + 6) @(negedge clk);
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d outstanding responses expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
